// File: rtl/running_light_pkg.sv
// Shared types and constants for the running-light checker.
//   state_t   : checker state (SEARCH, ACQ, LOCK)
//   DEF_WIDTH : default LED bus width
//   DEF_POS_W : position-index width for the default bus width
package running_light_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ACQ    = 2'd1,
      LOCK   = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_POS_W = $clog2(DEF_WIDTH);

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot decoder for the LED bus.
//   leds      : in,  WIDTH-bit observed LED bus
//   idx       : out, index of the lit bit (valid only when is_onehot=1)
//   is_onehot : out, 1 when exactly one bit of leds is set
module onehot_decode
   import running_light_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int POS_W = DEF_POS_W
) (
   input  logic [WIDTH-1:0] leds,
   output logic [POS_W-1:0] idx,
   output logic             is_onehot
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (leds[i]) begin
            idx = POS_W'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves zero only for a single-bit value.
   assign is_onehot = (leds != '0) && ((leds & (leds - WIDTH'(1))) == '0);

endmodule

// File: rtl/running_light_checker.sv
// Receive-side monitor for the bouncing one-hot LED pattern.
// Samples leds on each en strobe, locks onto a legal bounce sequence and
// flags illegal steps.
//   clk     : in,  system clock, rising edge
//   rst     : in,  asynchronous active-low reset
//   en      : in,  sample strobe (same clock-enable as the LED driver)
//   leds    : in,  observed LED bus
//   pos     : out, index of the lit LED at the last accepted sample
//   dir     : out, 0 = moving toward MSB, 1 = moving toward LSB
//   valid   : out, 1 while locked
//   bounce  : out, one-cycle pulse on a locked direction reversal
//   err     : out, one-cycle pulse on a detected violation
//   err_cnt : out, saturating violation count
// Optional: define RUNNING_LIGHT_CHECKER_SYNC_EN to pass leds/en through a
// two-flop synchronizer (adds 2 cycles of latency) for a foreign-clock bus.
module running_light_checker
   import running_light_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [WIDTH-1:0]         leds,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic                     dir,
   output logic                     valid,
   output logic                     bounce,
   output logic                     err,
   output logic [CNT_W-1:0]         err_cnt
);

   localparam int               POS_W   = $clog2(WIDTH);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   logic             en_s;
   logic [WIDTH-1:0] leds_s;

`ifdef RUNNING_LIGHT_CHECKER_SYNC_EN
   logic             en_p0, en_p1;
   logic [WIDTH-1:0] leds_p0, leds_p1;

   // Two-flop synchronizer stages
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_p0   <= 1'b0;
         en_p1   <= 1'b0;
         leds_p0 <= '0;
         leds_p1 <= '0;
      end else begin
         en_p0   <= en;
         en_p1   <= en_p0;
         leds_p0 <= leds;
         leds_p1 <= leds_p0;
      end
   end

   assign en_s   = en_p1;
   assign leds_s = leds_p1;
`else
   assign en_s   = en;
   assign leds_s = leds;
`endif

   logic [POS_W-1:0] idx;
   logic             is_oh;

   onehot_decode #(
      .WIDTH (WIDTH),
      .POS_W (POS_W)
   ) u_decode (
      .leds      (leds_s),
      .idx       (idx),
      .is_onehot (is_oh)
   );

   state_t           state;
   logic [POS_W-1:0] exp_pos;
   logic             exp_dir;
   logic             step_up;
   logic             step_dn;

   // Where a locked pattern must be next; reflects at both ends.
   always_comb begin
      exp_pos = pos;
      exp_dir = dir;
      if (!dir) begin
         if (pos == POS_MAX) begin
            exp_pos = POS_W'(WIDTH - 2);
            exp_dir = 1'b1;
         end else begin
            exp_pos = pos + POS_W'(1);
         end
      end else begin
         if (pos == '0) begin
            exp_pos = POS_W'(1);
            exp_dir = 1'b0;
         end else begin
            exp_pos = pos - POS_W'(1);
         end
      end
   end

   // End guards keep the index arithmetic from wrapping into a false match.
   assign step_up = (pos != POS_MAX) && (idx == pos + POS_W'(1));
   assign step_dn = (pos != '0)      && (idx == pos - POS_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= SEARCH;
         pos     <= '0;
         dir     <= 1'b0;
         bounce  <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         bounce <= 1'b0;
         err    <= 1'b0;
         if (en_s) begin
            unique case (state)
               SEARCH: begin
                  if (is_oh) begin
                     pos   <= idx;
                     state <= ACQ;
                  end
               end
               ACQ: begin
                  if (!is_oh) begin
                     state <= SEARCH;
                  end else if (step_up) begin
                     pos   <= idx;
                     dir   <= 1'b0;
                     state <= LOCK;
                  end else if (step_dn) begin
                     pos   <= idx;
                     dir   <= 1'b1;
                     state <= LOCK;
                  end else begin
                     pos <= idx;
                  end
               end
               LOCK: begin
                  if (is_oh && (idx == exp_pos)) begin
                     pos    <= exp_pos;
                     dir    <= exp_dir;
                     bounce <= (exp_dir != dir);
                  end else begin
                     // An unchanged bus is also a violation: the driver always moves.
                     err     <= 1'b1;
                     err_cnt <= sat_inc(err_cnt);
                     if (is_oh) begin
                        pos   <= idx;
                        state <= ACQ;
                     end else begin
                        state <= SEARCH;
                     end
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end

   assign valid = (state == LOCK);

endmodule

// File: tb/tb_running_light_checker.sv
module tb_running_light_checker;

   localparam int W    = 8;
   localparam int N    = 2 * W - 2;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic          en   = 1'b0;
   logic [W-1:0]  leds = '0;
   logic [2:0]    pos;
   logic          dir;
   logic          valid;
   logic          bounce;
   logic          err;
   logic [CW-1:0] err_cnt;

   int checks = 0;
   int passes = 0;

   // Reference model: mode 0 = searching, 1 = acquiring, 2 = locked.
   // While locked the pattern is tracked as a phase 0..N-1 around the bounce
   // cycle; position and direction are derived from the phase.
   int m_state, m_pos, m_dir, m_cnt, m_ph, m_bounce, m_err;

   running_light_checker #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .leds    (leds),
      .pos     (pos),
      .dir     (dir),
      .valid   (valid),
      .bounce  (bounce),
      .err     (err),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic void m_reset();
      m_state = 0; m_pos = 0; m_dir = 0; m_cnt = 0; m_ph = 0;
      m_bounce = 0; m_err = 0;
   endfunction

   function automatic int ph_pos(input int ph);
      return (ph < W) ? ph : N - ph;
   endfunction

   function automatic int ph_dir(input int ph);
      return (ph == 0 || ph >= W) ? 1 : 0;
   endfunction

   task automatic m_update(input logic e, input logic [W-1:0] l);
      int oh, idx, nph, ndir;
      m_bounce = 0;
      m_err    = 0;
      if (!e) return;
      oh  = ($countones(l) == 1) ? 1 : 0;
      idx = oh ? $clog2(l) : 0;
      if (m_state == 0) begin
         if (oh) begin m_pos = idx; m_state = 1; end
      end else if (m_state == 1) begin
         if (!oh) m_state = 0;
         else if (idx == m_pos + 1) begin
            m_pos = idx; m_dir = 0; m_ph = idx; m_state = 2;
         end else if (idx == m_pos - 1) begin
            m_pos = idx; m_dir = 1; m_ph = (idx == 0) ? 0 : N - idx; m_state = 2;
         end else m_pos = idx;
      end else begin
         nph = (m_ph + 1) % N;
         if (oh && idx == ph_pos(nph)) begin
            ndir = ph_dir(nph);
            m_bounce = (ndir != m_dir) ? 1 : 0;
            m_ph = nph; m_pos = ph_pos(nph); m_dir = ndir;
         end else begin
            m_err = 1;
            if (m_cnt < CMAX) m_cnt++;
            if (oh) begin m_pos = idx; m_state = 1; end
            else m_state = 0;
         end
      end
   endtask

   task automatic compare();
      chk("pos",     int'(pos),     m_pos);
      chk("dir",     int'(dir),     m_dir);
      chk("valid",   int'(valid),   (m_state == 2) ? 1 : 0);
      chk("bounce",  int'(bounce),  m_bounce);
      chk("err",     int'(err),     m_err);
      chk("err_cnt", int'(err_cnt), m_cnt);
   endtask

   task automatic step(input logic e, input logic [W-1:0] l);
      en   = e;
      leds = l;
      @(posedge clk);
      m_update(e, l);
      @(negedge clk);
      compare();
   endtask

   function automatic logic [W-1:0] rand_leds();
      int r, p;
      logic [W-1:0] v;
      r = $urandom_range(0, 9);
      if (r < 6) begin
         if (m_state == 2) p = ph_pos((m_ph + 1) % N);
         else p = (m_pos + 1 < W) ? m_pos + 1 : m_pos - 1;
         v = W'(1) << p;
      end else if (r == 6) v = W'(1) << $urandom_range(0, W - 1);
      else if (r == 7)     v = W'($urandom_range(0, 255));
      else if (r == 8)     v = '0;
      else                 v = leds;
      return v;
   endfunction

   initial begin
      m_reset();
      #1 rst = 1'b0;
      #3;
      compare();
      chk("reset_valid", int'(valid), 0);
      @(negedge clk);
      rst = 1'b1;

      // Initial lock and upward travel
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      chk("t1_valid", int'(valid), 1);
      chk("t1_dir",   int'(dir),   0);
      chk("t1_pos",   int'(pos),   1);
      step(1'b1, 8'h04);
      chk("t1_pos2",  int'(pos),   2);
      chk("t1_err",   int'(err),   0);

      // Bounce at the MSB and again at the LSB
      step(1'b1, 8'h08); step(1'b1, 8'h10); step(1'b1, 8'h20);
      step(1'b1, 8'h40); step(1'b1, 8'h80);
      step(1'b1, 8'h40);
      chk("t2_bounce_hi", int'(bounce),  1);
      chk("t2_dir_hi",    int'(dir),     1);
      chk("t2_pos_hi",    int'(pos),     6);
      chk("t2_cnt",       int'(err_cnt), 0);
      step(1'b1, 8'h20); step(1'b1, 8'h10); step(1'b1, 8'h08);
      step(1'b1, 8'h04); step(1'b1, 8'h02); step(1'b1, 8'h01);
      chk("t2_no_bounce_at_0", int'(bounce), 0);
      step(1'b1, 8'h02);
      chk("t2_bounce_lo", int'(bounce), 1);
      chk("t2_dir_lo",    int'(dir),    0);
      chk("t2_pos_lo",    int'(pos),    1);

      // Non-one-hot violation drops to search, then relock
      step(1'b1, 8'h04); step(1'b1, 8'h08);
      step(1'b1, 8'h18);
      chk("t3_err",   int'(err),     1);
      chk("t3_cnt",   int'(err_cnt), 1);
      chk("t3_valid", int'(valid),   0);
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      chk("t3_relock_pos",   int'(pos),   1);
      chk("t3_relock_valid", int'(valid), 1);

      // One-hot jump violation drops to acquire at the new index
      step(1'b1, 8'h04); step(1'b1, 8'h08);
      step(1'b1, 8'h20);
      chk("t4_err",   int'(err),   1);
      chk("t4_pos",   int'(pos),   5);
      chk("t4_valid", int'(valid), 0);
      step(1'b1, 8'h40);
      chk("t4_valid2", int'(valid),   1);
      chk("t4_dir",    int'(dir),     0);
      chk("t4_pos2",   int'(pos),     6);
      chk("t4_cnt",    int'(err_cnt), 2);

      // Enable low: everything holds, pulses stay quiet
      for (int i = 0; i < 5; i++) step(1'b0, W'($urandom_range(0, 255)));
      chk("t5_pos_hold",   int'(pos),   6);
      chk("t5_valid_hold", int'(valid), 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic e;
         logic [W-1:0] l;
         e = ($urandom_range(0, 4) != 0);
         l = rand_leds();
         step(e, l);
      end

      // Drive the counter into saturation
      step(1'b1, 8'h00);
      step(1'b1, 8'h08);
      step(1'b1, 8'h10);
      for (int i = 0; i < 150; i++) begin
         step(1'b1, 8'h10);
         step(1'b1, 8'h08);
         step(1'b1, 8'h08);
         step(1'b1, 8'h10);
      end
      chk("t6_cnt_sat", int'(err_cnt), CMAX);
      chk("t6_locked",  int'(valid),   1);

      // Asynchronous reset mid-lock, between clock edges
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_pos",    int'(pos),     0);
      chk("t6_rst_dir",    int'(dir),     0);
      chk("t6_rst_valid",  int'(valid),   0);
      chk("t6_rst_bounce", int'(bounce),  0);
      chk("t6_rst_err",    int'(err),     0);
      chk("t6_rst_cnt",    int'(err_cnt), 0);
      m_reset();
      @(negedge clk);
      compare();
      rst = 1'b1;
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      chk("t6_post_rst_valid", int'(valid), 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/running_light_checker.md
Name: running_light_checker

Overview:
- Receive-side monitor for the bouncing one-hot LED pattern driven onto the 8-bit LED bus.
- Samples the bus on each enable strobe and decodes the lit position and travel direction.
- Locks onto a legal bounce sequence and flags any illegal step with an error pulse and a saturating error counter.
- Sits beside the LED driver, sharing its clock and clock-enable; used in self-test and on-board diagnostics.

Parameters:
WIDTH, 8, LED bus width; the pattern bounces between bit 0 and bit WIDTH-1; minimum 2.
CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  sample strobe; the same clock-enable that advances the LED pattern.
leds  in  WIDTH  observed LED bus.
pos  out  clog2(WIDTH)  index of the lit LED at the last accepted sample.
dir  out  1  0 = moving toward MSB (left), 1 = moving toward LSB (right).
valid  out  1  1 while locked.
bounce  out  1  one-cycle pulse on a locked direction reversal.
err  out  1  one-cycle pulse on a detected violation.
err_cnt  out  CNT_W  saturating violation count.

Behaviour:
- Reset (rst=0): asynchronous. Takes effect immediately, including mid-lock. Clears state to SEARCH and sets pos=0, dir=0, valid=0, bounce=0, err=0, err_cnt=0.
- Sampling:
  - All updates occur on a clk rising edge where en=1; leds is evaluated combinationally at that edge.
  - Registered outputs are visible one cycle after the sampled edge.
  - With en=0, state, pos, dir, valid and err_cnt hold; bounce and err are forced to 0.
- Decode: oh = leds has exactly one bit set; idx = index of that bit.
- SEARCH state:
  - oh=1: capture pos=idx, go to ACQ.
  - Otherwise stay in SEARCH.
  - No errors are raised in SEARCH.
- ACQ state:
  - oh=0: go to SEARCH.
  - oh=1 and idx = pos+1: pos=idx, dir=0, go to LOCK.
  - oh=1 and idx = pos-1: pos=idx, dir=1, go to LOCK.
  - Any other one-hot value: pos=idx, stay in ACQ.
  - No errors are raised in ACQ.
- LOCK state, expected next position:
  - dir=0 and pos<WIDTH-1: pos+1.
  - dir=0 and pos=WIDTH-1: WIDTH-2, with dir flipping to 1.
  - dir=1 and pos>0: pos-1.
  - dir=1 and pos=0: 1, with dir flipping to 0.
- LOCK state, outcomes:
  - Match: update pos and dir; pulse bounce on a flip.
  - Mismatch (this includes an unchanged value, since the driver always moves when enabled): pulse err and increment err_cnt (saturating at 2^CNT_W-1). Then go to ACQ with pos=idx if oh=1, otherwise go to SEARCH.
- valid = (state==LOCK).
- dir holds its last value outside LOCK.
- bounce and err are never asserted together.

Optional Feature:
- Macro: RUNNING_LIGHT_CHECKER_SYNC_EN.
- When defined:
  - leds and en pass through a two-flop synchronizer, also reset asynchronously to 0, before decode.
  - This allows connection to an LED bus from an unrelated clock domain.
  - All responses shift 2 cycles later.
- When undefined: leds and en are used directly, with no added latency.

Decomposition:
- Package running_light_pkg holds:
  - state enum (SEARCH, ACQ, LOCK);
  - default WIDTH constant;
  - position-width constant derived from WIDTH.
- One natural sub-module, onehot_decode: combinational WIDTH-bit to index plus an is_onehot flag. Instantiated once.

Test Plan:
1. Reset release, then en=1 each cycle with leds = 01, 02, 04 -> after 02: valid=1, dir=0, pos=1. After 04: pos=2, err=0.
2. Continue the sweep to 80, then 40 -> at 40: bounce=1 for one cycle, dir=1, pos=6, err_cnt=0. Continue down to 01, then 02 -> bounce=1, dir=0, pos=1.
3. Locked at 08 (dir=0), inject 18 -> err=1 pulse, err_cnt=1, valid=0, state SEARCH. Then 01, 02 -> relock with pos=1.
4. Locked at 08 (dir=0), inject 20 -> err pulse, ACQ with pos=5, valid=0. Then 40 -> valid=1, dir=0, pos=6, err_cnt unchanged.
5. Locked, en=0 for 5 cycles while leds toggles randomly -> pos, dir, valid and err_cnt unchanged; err=0 and bounce=0 throughout.
6. Provoke 300 violations -> err_cnt saturates at 255. Then assert rst=0 mid-lock, asynchronous to clk -> all outputs 0 before the next clk edge.
